// File: rtl/scc_pkg.sv
// Shared SCC core types and default bus widths for the IF, EX, memory arbiter and top level.
// Pure declarations: no logic, no latency, no flow control.
package scc_pkg;

    localparam int SCC_ADDR_W = 32;
    localparam int SCC_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/scc_mem_arbiter_if.sv
// Hold-until-ack memory request bus; the master drives the request, the slave returns ack + rdata.
// On the memory side, ack carries mem_ready and rdata carries mem_rdata.
interface scc_mem_arbiter_if
    import scc_pkg::*;
#(
    parameter int ADDR_W = SCC_ADDR_W,
    parameter int DATA_W = SCC_DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/scc_mem_arbiter.sv
// Shares the single memory port between fetch and load/store; data wins, a streak limit protects fetch.
// Grant -> mem_req next cycle; mem_ready -> ack one cycle later; requesters hold req until their ack.
module scc_mem_arbiter
    import scc_pkg::*;
#(
    parameter int ADDR_W       = SCC_ADDR_W,
    parameter int DATA_W       = SCC_DATA_W,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    scc_mem_arbiter_if.slave     if_bus,
    scc_mem_arbiter_if.slave     d_bus,
    scc_mem_arbiter_if.master    mem_bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_IF_BUSY = IF_BUSY;
    localparam logic [1:0] S_D_BUSY  = D_BUSY;
    localparam logic [1:0] S_RESP    = RESP;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [1:0]        state_q,     state_d;
    arb_owner_t        owner_q,     owner_d;
    logic [3:0]        streak_q,    streak_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q,    if_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              grant_if;
    logic              grant_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        grant_if    = 1'b0;
        grant_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Fetch only wins a contested cycle once data has used up its streak.
                grant_if = if_bus.req && (!d_bus.req || streak_q == STREAK_MAX);
                grant_d  = d_bus.req && !grant_if;

                if (grant_if) begin
                    state_d     = S_IF_BUSY;
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_bus.addr;
                    mem_wdata_d = '0;
                    streak_d    = '0;
                end else if (grant_d) begin
                    state_d     = S_D_BUSY;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_bus.we;
                    mem_addr_d  = d_bus.addr;
                    mem_wdata_d = d_bus.wdata;
                    if (!if_bus.req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else begin
                    streak_d = '0;
                end
            end

            S_IF_BUSY, S_D_BUSY: begin
                if (mem_bus.ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_bus.rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_bus.rdata;
                        end
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_bus.req   = mem_req_q;
    assign mem_bus.we    = mem_we_q;
    assign mem_bus.addr  = mem_addr_q;
    assign mem_bus.wdata = mem_wdata_q;
    assign if_bus.ack    = if_ack_q;
    assign if_bus.rdata  = if_rdata_q;
    assign d_bus.ack     = d_ack_q;
    assign d_bus.rdata   = d_rdata_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Randomized bench for scc_mem_arbiter: the bench plays both requesters and the memory,
// and predicts every output from a transaction timeline (grant cycle g, memory latency k).
module tb_scc_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int NCYC = 4500;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_bus ();
    scc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
    scc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    scc_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_D_STREAK (MAXS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_bus  (if_bus),
        .d_bus   (d_bus),
        .mem_bus (mem_bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // Transaction-level reference: one transaction at a time, granted in cycle g,
    // memory completes in cycle g+k, ack in g+k+1, arbiter samples again in g+k+2.
    bit          busy, t_d, t_we;
    logic [31:0] t_addr, t_wdata;
    int          g, k, streak;
    logic [31:0] e_addr, e_wdata, e_ifr, e_dr;
    bit          e_we;
    bit          pend_if, pend_d, acked_if, acked_d, rst_arm;
    bit          in_reset, in_win, ifr, dr;
    int          preq_if, keep_if, preq_d, keep_d;
    logic [31:0] r;
    int          n_if_grants, n_d_grants, n_resets;

    initial begin
        busy = 0; t_d = 0; t_we = 0; t_addr = '0; t_wdata = '0; g = 0; k = 1; streak = 0;
        e_addr = '0; e_wdata = '0; e_ifr = '0; e_dr = '0; e_we = 0;
        pend_if = 0; pend_d = 0; acked_if = 0; acked_d = 0; rst_arm = 0;
        n_if_grants = 0; n_d_grants = 0; n_resets = 0;
        reset = 1'b1;
        if_bus.req = 0; if_bus.we = 0; if_bus.addr = '0; if_bus.wdata = '0;
        d_bus.req = 0; d_bus.we = 0; d_bus.addr = '0; d_bus.wdata = '0;
        mem_bus.ack = 0; mem_bus.rdata = '0;
        @(posedge clk);
        #1;

        for (int c = 0; c < NCYC; c++) begin
            cyc = c;
            if (c < 1500) begin
                preq_if = 30; keep_if = 40; preq_d = 30; keep_d = 40;
            end else if (c < 3000) begin
                preq_if = 100; keep_if = 100; preq_d = 100; keep_d = 100;
            end else begin
                preq_if = 10; keep_if = 0; preq_d = 90; keep_d = 90;
            end
            if (c == 1000 || c == 2200 || c == 3800) rst_arm = 1;

            in_reset = (c < 2);
            if (rst_arm && busy && t_d && c == g + 1 && k >= 2) begin
                in_reset = 1;
                rst_arm  = 0;
            end

            if (acked_if) begin
                acked_if = 0;
                pend_if  = (int'($urandom_range(99)) < keep_if);
                if (pend_if) begin r = $urandom(); if_bus.addr = {r[31:2], 2'b00}; end
            end else if (!pend_if && int'($urandom_range(99)) < preq_if) begin
                pend_if = 1;
                r = $urandom(); if_bus.addr = {r[31:2], 2'b00};
            end
            if (!pend_if) if_bus.addr = $urandom();
            if_bus.req = pend_if;

            if (acked_d) begin
                acked_d = 0;
                pend_d  = (int'($urandom_range(99)) < keep_d);
                if (pend_d) begin
                    r = $urandom(); d_bus.addr = {r[31:2], 2'b01};
                    d_bus.we = $urandom_range(1); d_bus.wdata = $urandom();
                end
            end else if (!pend_d && int'($urandom_range(99)) < preq_d) begin
                pend_d = 1;
                r = $urandom(); d_bus.addr = {r[31:2], 2'b01};
                d_bus.we = $urandom_range(1); d_bus.wdata = $urandom();
            end
            if (!pend_d) begin
                d_bus.addr = $urandom(); d_bus.we = $urandom_range(1); d_bus.wdata = $urandom();
            end
            d_bus.req = pend_d;

            in_win        = busy && c > g && c <= g + k;
            mem_bus.ack   = in_win ? (c == g + k) : ($urandom_range(3) == 0);
            mem_bus.rdata = $urandom();
            reset         = in_reset;

            @(negedge clk);
            chk("mem_req",   32'(mem_bus.req), 32'(in_win));
            chk("mem_addr",  mem_bus.addr, e_addr);
            chk("mem_we",    32'(mem_bus.we), 32'(e_we));
            chk("mem_wdata", mem_bus.wdata, e_wdata);
            chk("if_ack",    32'(if_bus.ack), 32'(busy && c == g + k + 1 && !t_d));
            chk("d_ack",     32'(d_bus.ack), 32'(busy && c == g + k + 1 && t_d));
            chk("if_rdata",  if_bus.rdata, e_ifr);
            chk("d_rdata",   d_bus.rdata, e_dr);

            if (in_reset) begin
                if (c >= 2) n_resets++;
                busy = 0; streak = 0;
                e_addr = '0; e_wdata = '0; e_we = 0; e_ifr = '0; e_dr = '0;
                pend_if = 0; pend_d = 0; acked_if = 0; acked_d = 0;
            end else if (!busy) begin
                ifr = if_bus.req;
                dr  = d_bus.req;
                if (ifr && (!dr || streak == MAXS)) begin
                    busy = 1; g = c; k = $urandom_range(1, 4);
                    t_d = 0; t_we = 0; t_addr = if_bus.addr; t_wdata = '0;
                    streak = 0;
                    n_if_grants++;
                end else if (dr) begin
                    busy = 1; g = c; k = $urandom_range(1, 4);
                    t_d = 1; t_we = d_bus.we; t_addr = d_bus.addr; t_wdata = d_bus.wdata;
                    streak = ifr ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
                    n_d_grants++;
                end else begin
                    streak = 0;
                end
                if (busy) begin
                    e_addr = t_addr; e_we = t_we; e_wdata = t_wdata;
                end
            end else if (c == g + k) begin
                if (!t_d) e_ifr = mem_bus.rdata;
                else if (!t_we) e_dr = mem_bus.rdata;
            end else if (c == g + k + 1) begin
                busy = 0;
                if (t_d) acked_d = 1;
                else acked_if = 1;
            end

            @(posedge clk);
            #1;
        end

        cyc = NCYC;
        chk("if_grants_seen", 32'(n_if_grants > 20), 32'd1);
        chk("d_grants_seen",  32'(n_d_grants > 20), 32'd1);
        chk("mid_txn_resets", 32'(n_resets), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scc_mem_arbiter.md
# scc_mem_arbiter

Shares the single external memory port of the SCC core between the instruction-fetch path and the load/store path. Each requester uses a hold-until-ack handshake. The arbiter runs a small FSM that drives one registered transaction at a time onto the memory port and waits for a variable-latency `mem_ready`. Data accesses have priority, and a streak limit guarantees fetch forward progress. It sits between the IF/EX stages and the memory interface of the top level.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_D_STREAK`, default 4: maximum consecutive data grants while a fetch is pending. Range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address; stable while `if_req`.
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  DATA_W  fetched instruction, registered.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ack`  out  1  one-cycle pulse; `d_rdata` valid for loads.
- `d_rdata`  out  DATA_W  load data, registered.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  completes the current transaction in this cycle.

## Operation
- FSM states:
  - IDLE
  - IF_BUSY
  - D_BUSY
  - RESP
- IDLE:
  - Neither request: stay.
  - Only `d_req`: grant data.
  - Only `if_req`: grant fetch.
  - Both: grant fetch if `streak == MAX_D_STREAK`; otherwise grant data.
- On a grant:
  - Register `mem_addr` and `mem_we` (0 for fetch).
  - Register `mem_wdata` (fetch: 0).
  - Set `mem_req`=1.
  - Go to IF_BUSY or D_BUSY.
- *_BUSY:
  - Hold all `mem_*` outputs constant until `mem_ready`=1.
  - On `mem_ready`:
    - Capture `mem_rdata` into `if_rdata`, or into `d_rdata` for loads only; stores leave `d_rdata` unchanged.
    - Clear `mem_req`.
    - Go to RESP with a latched owner.
- RESP:
  - Pulse the owner's ack for exactly one cycle.
  - Go to IDLE.
  - Requests are not sampled in RESP.
- Requester rule:
  - Deassert `req` at the edge ending the ack cycle, or keep it high to issue a new request with new inputs.
  - A `req` still high in the following IDLE cycle is a new request.
- Streak counter, 4 bits:
  - Data grant while `if_req`=1: increment, saturating at `MAX_D_STREAK`.
  - Fetch grant: clear to 0.
  - IDLE cycle with `if_req`=0: clear to 0.
- `if_rdata` and `d_rdata` hold their last values between acks.

## Timing
- Reset values:
  - State = IDLE, streak = 0.
  - `mem_req`, `mem_we`, `if_ack`, `d_ack` = 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
- Latency:
  - Request seen in IDLE at cycle t gives `mem_req`=1 at t+1.
  - `mem_ready` at cycle t+k (k≥1) gives ack at t+k+1 and IDLE at t+k+2.
  - Minimum request-to-ack is 2 cycles; back-to-back throughput is one transaction per 3 cycles.
- `mem_ready` while `mem_req`=0 is ignored.
- A reset in any state, mid-transaction included, forces all reset values at that edge. The outstanding memory transaction is abandoned, no ack is issued, and requesters must re-request.
- Request changes during BUSY or RESP have no effect until IDLE.

## Structure
- Shared package `scc_pkg`:
  - `arb_state_t` enum: IDLE, IF_BUSY, D_BUSY, RESP.
  - `arb_owner_t`: OWN_IF, OWN_D.
  - Default `ADDR_W` and `DATA_W` constants, shared with the IF, EX and top level.
- Single module; no sub-module needed. The streak counter is inline (about 10 lines).

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x0000_0010, `mem_ready` on the first BUSY cycle with `mem_rdata`=0xDEAD_BEEF → `mem_req` high for 1 cycle with `mem_addr`=0x10 and `mem_we`=0; `if_ack` 2 cycles after the request with `if_rdata`=0xDEAD_BEEF.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0x1234_5678, memory waits 3 cycles → `mem_wdata` held for 3 cycles; `d_ack` at request+4; `d_rdata` unchanged.
- Simultaneous `if_req` and `d_req`, both held with new requests re-issued, `MAX_D_STREAK`=4 → grant order D, D, D, D, IF; streak then returns to 0.
- Load grant while `if_req`=0, then fetch appears → streak stays 0; the next contested IDLE grants data.
- Reset asserted in D_BUSY (`mem_ready`=0) → next cycle: `mem_req`=0, state IDLE, no `d_ack`, and all outputs at reset values.
- Requester holds `d_req` through the ack → a second data transaction starts in the IDLE following RESP; `mem_req` is low for exactly 2 cycles between the two transactions.
